compare_bank: RTL and testbench

Parametrised, pipelined replacement for the single-value comparator bank. Each accepted sample `a_in` is compared against every index `0..N_OUT-1` under a selectable mode: equality/one-hot, thermometer, or tolerance window. The block returns the match vector, its popcount and running statistics over a valid/ready stream. It sits between a sample producer and any decode/classification consumer that needs back-pressure.

---
 rtl/compare_pkg.sv | 16 +
 rtl/compare_cell.sv | 36 +++
 rtl/compare_bank.sv | 145 ++++++++++++++
 tb/tb_compare_bank.sv | 314 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/compare_pkg.sv
// Shared mode encoding and width helper for the compare bank and its cells.
package compare_pkg;

  typedef enum logic [1:0] {
    CMP_EQ   = 2'b00,
    CMP_GE   = 2'b01,
    CMP_WIN  = 2'b10,
    CMP_RSVD = 2'b11
  } cmp_mode_e;

  // Bits needed to hold a popcount of 0..n_out inclusive.
  function automatic int hit_cnt_width(input int n_out);
    return $clog2(n_out + 1);
  endfunction

endpackage

// File: rtl/compare_cell.sv
// Single-index comparator: decides whether sample a matches INDEX under the given mode.
module compare_cell
  import compare_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int INDEX = 0
) (
  input  logic [WIDTH-1:0] a,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] tol,
  output logic             match
);

  localparam logic [WIDTH:0] IDX = (WIDTH + 1)'(INDEX);

  cmp_mode_e      mode_e;
  logic [WIDTH:0] a_ext;
  logic [WIDTH:0] tol_ext;
  logic [WIDTH:0] diff;

  // Distance is taken one bit wider and always non-negative, so the window clips at the ends.
  always_comb begin
    mode_e  = cmp_mode_e'(mode);
    a_ext   = {1'b0, a};
    tol_ext = {1'b0, tol};
    diff    = (a_ext >= IDX) ? (a_ext - IDX) : (IDX - a_ext);
    match   = 1'b0;
    case (mode_e)
      CMP_EQ:  match = (a_ext == IDX);
      CMP_GE:  match = (a_ext >= IDX);
      CMP_WIN: match = (diff <= tol_ext);
      default: match = 1'b0;
    endcase
  end

endmodule

// File: rtl/compare_bank.sv
// Two-stage valid/ready comparator bank: stage 1 holds the sample, stage 2 the match vector,
// popcount and reserved-mode tag; miss/err statistics update on each output handshake.
module compare_bank
  import compare_pkg::*;
#(
  parameter  int WIDTH = 4,
  parameter  int N_OUT = 2**WIDTH,
  parameter  int CNT_W = 8,
  localparam int HIT_W = hit_cnt_width(N_OUT)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a_in,
  input  logic [1:0]       mode,
  input  logic [WIDTH-1:0] tol,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [N_OUT-1:0] b_out,
  output logic [HIT_W-1:0] hit_cnt,
  output logic [CNT_W-1:0] miss_cnt,
  output logic             err,
  input  logic             clr
);

  logic             s1_valid_q, s1_valid_d;
  logic [WIDTH-1:0] a_q, a_d;
  cmp_mode_e        mode_q, mode_d;
  logic [WIDTH-1:0] tol_q, tol_d;

  logic             s2_valid_q, s2_valid_d;
  logic [N_OUT-1:0] b_q, b_d;
  logic [HIT_W-1:0] hit_q, hit_d;
  logic             rsvd_q, rsvd_d;

  logic [CNT_W-1:0] miss_q, miss_d;
  logic             err_q, err_d;

  logic             s1_adv;
  logic             accept;
  logic             consume;
  logic [N_OUT-1:0] match;
  logic [HIT_W-1:0] match_cnt;

  assign s1_adv  = !s2_valid_q || out_ready;
  assign in_ready = !s1_valid_q || s1_adv;
  assign accept  = in_valid && in_ready;
  assign consume = s2_valid_q && out_ready;

  for (genvar i = 0; i < N_OUT; i++) begin : g_cell
    compare_cell #(
      .WIDTH(WIDTH),
      .INDEX(i)
    ) u_cell (
      .a    (a_q),
      .mode (mode_q),
      .tol  (tol_q),
      .match(match[i])
    );
  end

  always_comb begin
    match_cnt = '0;
    for (int i = 0; i < N_OUT; i++) begin
      match_cnt = match_cnt + HIT_W'(match[i]);
    end
  end

  // Stage 2 only loads from stage 1 when it is empty or being drained this edge.
  always_comb begin
    s1_valid_d = accept || (s1_valid_q && !s1_adv);
    a_d        = a_q;
    mode_d     = mode_q;
    tol_d      = tol_q;
    if (accept) begin
      a_d    = a_in;
      mode_d = cmp_mode_e'(mode);
      tol_d  = tol;
    end

    s2_valid_d = s2_valid_q;
    b_d        = b_q;
    hit_d      = hit_q;
    rsvd_d     = rsvd_q;
    if (s1_adv) begin
      s2_valid_d = s1_valid_q;
      if (s1_valid_q) begin
        b_d    = match;
        hit_d  = match_cnt;
        rsvd_d = (mode_q == CMP_RSVD);
      end
    end
  end

  // Clear wins over any same-cycle increment or error set.
  always_comb begin
    miss_d = miss_q;
    err_d  = err_q;
    if (clr) begin
      miss_d = '0;
      err_d  = 1'b0;
    end else if (consume) begin
      if ((hit_q == '0) && (miss_q != '1)) begin
        miss_d = miss_q + CNT_W'(1);
      end
      if (rsvd_q) begin
        err_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid_q <= 1'b0;
      a_q        <= '0;
      mode_q     <= CMP_EQ;
      tol_q      <= '0;
      s2_valid_q <= 1'b0;
      b_q        <= '0;
      hit_q      <= '0;
      rsvd_q     <= 1'b0;
      miss_q     <= '0;
      err_q      <= 1'b0;
    end else begin
      s1_valid_q <= s1_valid_d;
      a_q        <= a_d;
      mode_q     <= mode_d;
      tol_q      <= tol_d;
      s2_valid_q <= s2_valid_d;
      b_q        <= b_d;
      hit_q      <= hit_d;
      rsvd_q     <= rsvd_d;
      miss_q     <= miss_d;
      err_q      <= err_d;
    end
  end

  assign out_valid = s2_valid_q;
  assign b_out     = b_q;
  assign hit_cnt   = hit_q;
  assign miss_cnt  = miss_q;
  assign err       = err_q;

endmodule

// File: tb/tb_compare_bank.sv
// Self-checking bench for compare_bank: a queue-based reference model checked every negedge,
// plus directed samples with hand-computed literal results.
module tb_compare_bank;

  localparam int WIDTH = 4;
  localparam int N_OUT = 16;
  localparam int CNT_W = 8;
  localparam int HIT_W = 5;

  logic             clk;
  logic             rst_n;
  logic             in_valid;
  logic             in_ready;
  logic [WIDTH-1:0] a_in;
  logic [1:0]       mode;
  logic [WIDTH-1:0] tol;
  logic             out_valid;
  logic             out_ready;
  logic [N_OUT-1:0] b_out;
  logic [HIT_W-1:0] hit_cnt;
  logic [CNT_W-1:0] miss_cnt;
  logic             err;
  logic             clr;

  int total;
  int bad;
  int cyc;

  typedef struct {
    logic [15:0] b;
    int          hit;
    int          mode;
    int          acc;
  } exp_t;

  exp_t q[$];
  int   miss_m;
  int   err_m;
  bit   exp_valid;
  bit   exp_ready;
  exp_t item;

  compare_bank #(
    .WIDTH(WIDTH),
    .N_OUT(N_OUT),
    .CNT_W(CNT_W)
  ) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a_in     (a_in),
    .mode     (mode),
    .tol      (tol),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .b_out    (b_out),
    .hit_cnt  (hit_cnt),
    .miss_cnt (miss_cnt),
    .err      (err),
    .clr      (clr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(posedge clk) cyc++;

  // Match vector straight from the per-index rules, using plain integer distance.
  function automatic logic [15:0] modelVec(input int a, input int m, input int t);
    logic [15:0] v;
    int d;
    v = '0;
    for (int i = 0; i < N_OUT; i++) begin
      d = (a > i) ? (a - i) : (i - a);
      case (m)
        0:       v[i] = (a == i);
        1:       v[i] = (a >= i);
        2:       v[i] = (d <= t);
        default: v[i] = 1'b0;
      endcase
    end
    return v;
  endfunction

  task automatic checkOutput(input string name, input logic [31:0] got, input logic [31:0] expv);
    total++;
    if (got !== expv) begin
      bad++;
      $display("[TB] FAIL %s actual=%0h required=%0h at %0t", name, got, expv, $time);
    end
  endtask

  // Reference model: results leave in order; the oldest one is visible one edge after its
  // accepting edge, and the bank can only refuse input while holding two results unconsumed.
  always @(negedge clk) begin
    if (!rst_n) begin
      q.delete();
      miss_m = 0;
      err_m  = 0;
    end else begin
      exp_valid = 1'b0;
      if (q.size() > 0) exp_valid = (cyc >= q[0].acc + 1);
      exp_ready = !((q.size() == 2) && !out_ready);
      checkOutput("m_out_valid", 32'(out_valid), 32'(exp_valid));
      checkOutput("m_in_ready", 32'(in_ready), 32'(exp_ready));
      if (exp_valid) begin
        checkOutput("m_b_out", 32'(b_out), 32'(q[0].b));
        checkOutput("m_hit_cnt", 32'(hit_cnt), 32'(q[0].hit));
      end
      checkOutput("m_miss_cnt", 32'(miss_cnt), 32'(miss_m));
      checkOutput("m_err", 32'(err), 32'(err_m));
      if (clr) begin
        miss_m = 0;
        err_m  = 0;
      end else if (exp_valid && out_ready) begin
        if (q[0].hit == 0 && miss_m < 255) miss_m++;
        if (q[0].mode == 3) err_m = 1;
      end
      if (exp_valid && out_ready) void'(q.pop_front());
      if (in_valid && exp_ready) begin
        item.b    = modelVec(int'(a_in), int'(mode), int'(tol));
        item.hit  = $countones(item.b);
        item.mode = int'(mode);
        item.acc  = cyc + 1;
        q.push_back(item);
      end
    end
  end

  // Offers one sample from posedge+1 until it is accepted; returns at posedge+1 after acceptance.
  task automatic applyStimulus(input logic [3:0] a, input logic [1:0] m, input logic [3:0] t);
    int n;
    n = 0;
    @(posedge clk);
    #1;
    in_valid = 1'b1;
    a_in     = a;
    mode     = m;
    tol      = t;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) checkOutput("accept_timeout", 32'(n), 32'(0));
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  // Sends a sample with out_ready high and checks the literal result when it appears.
  task automatic runSample(input string name, input logic [3:0] a, input logic [1:0] m,
                           input logic [3:0] t, input logic [15:0] exp_b, input int exp_h);
    int n;
    applyStimulus(a, m, t);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!out_valid && n < 10);
    checkOutput({name, "_latency"}, 32'(n), 32'(2));
    checkOutput({name, "_b"}, 32'(b_out), 32'(exp_b));
    checkOutput({name, "_hit"}, 32'(hit_cnt), 32'(exp_h));
  endtask

  initial begin
    int n;
    int guard;
    total     = 0;
    bad       = 0;
    cyc       = 0;
    rst_n     = 1'b0;
    in_valid  = 1'b0;
    a_in      = '0;
    mode      = '0;
    tol       = '0;
    out_ready = 1'b1;
    clr       = 1'b0;
    #1;
    checkOutput("rst_in_ready", 32'(in_ready), 32'(1));
    checkOutput("rst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("rst_b_out", 32'(b_out), 32'(0));
    checkOutput("rst_hit_cnt", 32'(hit_cnt), 32'(0));
    checkOutput("rst_miss_cnt", 32'(miss_cnt), 32'(0));
    checkOutput("rst_err", 32'(err), 32'(0));
    @(negedge clk);
    #2 rst_n = 1'b1;

    runSample("eq5",   4'd5,  2'b00, 4'd0, 16'h0020, 1);
    runSample("ge3",   4'd3,  2'b01, 4'd0, 16'h000F, 4);
    runSample("ge15",  4'd15, 2'b01, 4'd0, 16'hFFFF, 16);
    runSample("win0",  4'd0,  2'b10, 4'd2, 16'h0007, 3);
    runSample("win15", 4'd15, 2'b10, 4'd1, 16'hC000, 2);
    runSample("win7",  4'd7,  2'b10, 4'd0, 16'h0080, 1);

    // Back-pressure: two samples fill the pipe, the third is held off.
    @(posedge clk);
    #1;
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_in      = 4'd1;
    mode      = 2'b00;
    tol       = 4'd0;
    @(negedge clk);
    checkOutput("bp_ready1", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1 a_in = 4'd2;
    @(negedge clk);
    checkOutput("bp_ready2", 32'(in_ready), 32'(1));
    @(posedge clk);
    #1 a_in = 4'd3;
    repeat (3) begin
      @(negedge clk);
      checkOutput("bp_full_ready", 32'(in_ready), 32'(0));
      checkOutput("bp_hold_valid", 32'(out_valid), 32'(1));
      checkOutput("bp_hold_b", 32'(b_out), 32'h0002);
    end
    @(posedge clk);
    #1 out_ready = 1'b1;
    @(negedge clk);
    checkOutput("bp_order0", 32'(b_out), 32'h0002);
    @(posedge clk);
    #1 in_valid = 1'b0;
    @(negedge clk);
    checkOutput("bp_order1", 32'(b_out), 32'h0004);
    @(negedge clk);
    checkOutput("bp_order2", 32'(b_out), 32'h0008);

    runSample("rsvd9", 4'd9, 2'b11, 4'd0, 16'h0000, 0);
    @(posedge clk);
    #1;
    checkOutput("rsvd_err", 32'(err), 32'(1));
    checkOutput("rsvd_miss", 32'(miss_cnt), 32'(1));

    // Stream 257 reserved-mode samples; the miss counter must stop at 255.
    in_valid = 1'b1;
    a_in     = 4'd0;
    mode     = 2'b11;
    n        = 0;
    guard    = 0;
    while (n < 257 && guard < 400) begin
      @(negedge clk);
      if (in_ready) n++;
      guard++;
      @(posedge clk);
      #1;
    end
    in_valid = 1'b0;
    checkOutput("stats_accepts", 32'(n), 32'(257));
    repeat (4) @(posedge clk);
    #1;
    checkOutput("stats_miss_sat", 32'(miss_cnt), 32'(255));
    checkOutput("stats_err", 32'(err), 32'(1));

    // Clear coincides with a reserved-mode handshake and must win.
    applyStimulus(4'd0, 2'b11, 4'd0);
    @(posedge clk);
    #1;
    checkOutput("clr_pre_valid", 32'(out_valid), 32'(1));
    clr = 1'b1;
    @(posedge clk);
    #1;
    clr = 1'b0;
    checkOutput("clr_miss", 32'(miss_cnt), 32'(0));
    checkOutput("clr_err", 32'(err), 32'(0));

    // Reset with both stages full.
    runSample("rsvd2", 4'd2, 2'b11, 4'd0, 16'h0000, 0);
    @(posedge clk);
    #1;
    checkOutput("pre_rst_miss", 32'(miss_cnt), 32'(1));
    checkOutput("pre_rst_err", 32'(err), 32'(1));
    out_ready = 1'b0;
    in_valid  = 1'b1;
    a_in      = 4'd4;
    mode      = 2'b00;
    @(posedge clk);
    #1 a_in = 4'd5;
    @(posedge clk);
    #1 in_valid = 1'b0;
    checkOutput("rst_full_valid", 32'(out_valid), 32'(1));
    checkOutput("rst_full_ready", 32'(in_ready), 32'(0));
    #2 rst_n = 1'b0;
    #1;
    checkOutput("arst_in_ready", 32'(in_ready), 32'(1));
    checkOutput("arst_out_valid", 32'(out_valid), 32'(0));
    checkOutput("arst_b_out", 32'(b_out), 32'(0));
    checkOutput("arst_hit_cnt", 32'(hit_cnt), 32'(0));
    checkOutput("arst_miss_cnt", 32'(miss_cnt), 32'(0));
    checkOutput("arst_err", 32'(err), 32'(0));
    repeat (2) @(posedge clk);
    #3;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    repeat (6) begin
      @(negedge clk);
      checkOutput("no_stale", 32'(out_valid), 32'(0));
    end

    runSample("post_eq6", 4'd6, 2'b00, 4'd0, 16'h0040, 1);
    repeat (3) @(posedge clk);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #500000;
    $display("[TB] FAIL watchdog actual=timeout required=finish");
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
